// File: rtl/tag_lookup_pkg.sv
// Shared types and constants for the tag lookup controller: FSM encoding and RAM word layout.
// The INIT state exists only when TAG_LOOKUP_INIT_EN is defined.
package tag_lookup_pkg;

`ifdef TAG_LOOKUP_INIT_EN
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CMP   = 3'd3,
    ST_WRITE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CMP   = 3'd3,
    ST_WRITE = 3'd4
  } state_t;
`endif

  localparam int DEF_AWIDTH = 3;
  localparam int DEF_DWIDTH = 14;
  localparam int VALID_BIT  = DEF_DWIDTH - 1;
  localparam int TAG_W      = DEF_DWIDTH - 1;

  // Valid flag sits in the MSB; the tag fills everything below it.
  function automatic int valid_bit_of(input int dwidth);
    return dwidth - 1;
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Request, response and tag-RAM signals of the tag lookup controller.
// slave = controller side, master = requester / RAM owner side.
interface tag_lookup_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_inv;
  logic              req_alloc;
  logic [AWIDTH-1:0] req_index;
  logic [DWIDTH-2:0] req_tag;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_inv, req_alloc, req_index, req_tag, ram_dout,
    output req_ready, rsp_valid, rsp_hit, ram_addr, ram_din, ram_we
  );

  modport master (
    output req_valid, req_inv, req_alloc, req_index, req_tag, ram_dout,
    input  req_ready, rsp_valid, rsp_hit, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup/allocate/invalidate over an external 1-cycle-read RAM; lookup rsp 2 cycles after accept, invalidate 1.
// One request at a time (req_ready only in IDLE); TAG_LOOKUP_INIT_EN adds a RAM-clearing INIT pass after reset.
module tag_lookup_ctrl
  import tag_lookup_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  tag_lookup_ctrl_if.slave  bus
);

  localparam int TW    = valid_bit_of(DWIDTH);
  localparam int DEPTH = 1 << AWIDTH;

`ifdef TAG_LOOKUP_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  logic [AWIDTH-1:0] init_cnt;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t            state, state_nx;
  logic [AWIDTH-1:0] idx_q;
  logic [TW-1:0]     tag_q;
  logic              inv_q;
  logic              alloc_q;
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic              rdy_c;
  logic              we_c;
  logic [AWIDTH-1:0] addr_c;
  logic [DWIDTH-1:0] din_c;
  logic              accept;
  logic              hit;

  assign accept = bus.req_valid && rdy_c;
  assign hit    = bus.ram_dout[DWIDTH-1] && (bus.ram_dout[TW-1:0] == tag_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      tag_q   <= '0;
      inv_q   <= 1'b0;
      alloc_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= bus.req_index;
      tag_q   <= bus.req_tag;
      inv_q   <= bus.req_inv;
      alloc_q <= bus.req_alloc;
    end
  end

  // Response strobes on the edge that leaves CMP, or WRITE when invalidating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      if (state == ST_CMP) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= hit;
      end else if (state == ST_WRITE && inv_q) begin
        rsp_valid_q <= 1'b1;
      end
    end
  end

`ifdef TAG_LOOKUP_INIT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               init_cnt <= '0;
    else if (state == ST_INIT)  init_cnt <= init_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    rdy_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = '0;
    din_c    = '0;
    case (state)
`ifdef TAG_LOOKUP_INIT_EN
      ST_INIT: begin
        we_c   = 1'b1;
        addr_c = init_cnt;
        if (init_cnt == AWIDTH'(DEPTH - 1)) state_nx = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        rdy_c = 1'b1;
        if (bus.req_valid) state_nx = bus.req_inv ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        addr_c   = idx_q;
        state_nx = ST_CMP;
      end
      ST_CMP: begin
        addr_c   = idx_q;
        state_nx = (!hit && alloc_q) ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE: begin
        we_c     = 1'b1;
        addr_c   = idx_q;
        din_c    = inv_q ? '0 : {1'b1, tag_q};
        state_nx = ST_IDLE;
      end
      default: state_nx = RST_STATE;
    endcase
  end

  // Gating with reset_n forces every output low while reset is held and drops ram_we at once.
  assign bus.req_ready = rdy_c & reset_n;
  assign bus.ram_we    = we_c & reset_n;
  assign bus.ram_addr  = addr_c & {AWIDTH{reset_n}};
  assign bus.ram_din   = din_c & {DWIDTH{reset_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Randomized bench for tag_lookup_ctrl: tag-directory reference model, scoreboard queues and a negedge monitor.
// The parent RAM is modelled here; builds with or without TAG_LOOKUP_INIT_EN.
module tb_tag_lookup_ctrl;
  import tag_lookup_pkg::*;

  localparam int AW    = 3;
  localparam int DW    = 14;
  localparam int TW    = DW - 1;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit hit;
    int acc;
    int lat;
  } rsp_e;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_e;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tag_lookup_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  rsp_e rq[$];
  wr_e  wq[$];
  int   dir[DEPTH];            // -1 = entry invalid, otherwise the stored tag
  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] preload[DEPTH];
  logic load_en = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= preload[i];
    end else begin
      bus.ram_dout <= mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expected responses and RAM writes as the DUT presents them.
  rsp_e me;
  wr_e  mw;
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          me = rq.pop_front();
          chk("rsp_hit", bus.rsp_hit, me.hit);
          chk("rsp_latency", cyc - me.acc, me.lat);
        end
      end
      if (bus.ram_we) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          mw = wq.pop_front();
          chk("write_addr", bus.ram_addr, mw.a);
          chk("write_din", bus.ram_din, mw.d);
        end
      end else begin
        chk("idle_din", bus.ram_din, 0);
      end
    end
  end

  task automatic model(input bit inv, input bit alloc, input int idx, input logic [TW-1:0] tag);
    bit h;
    if (inv) begin
      rq.push_back('{hit: 1'b0, acc: cyc, lat: 1});
      wq.push_back('{a: AW'(idx), d: '0});
      dir[idx] = -1;
    end else begin
      h = (dir[idx] == int'(tag));
      rq.push_back('{hit: h, acc: cyc, lat: 2});
      if (!h && alloc) begin
        wq.push_back('{a: AW'(idx), d: {1'b1, tag}});
        dir[idx] = int'(tag);
      end
    end
  endtask

  task automatic send(input bit inv, input bit alloc, input int idx, input logic [TW-1:0] tag, input int gap);
    bit ok = 1'b0;
    @(negedge clock);
    if (gap > 0) begin
      bus.req_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    bus.req_valid = 1'b1;
    bus.req_inv   = inv;
    bus.req_alloc = alloc;
    bus.req_index = AW'(idx);
    bus.req_tag   = tag;
    for (int k = 0; k < 40; k++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      timeout("req_accept");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    model(inv, alloc, idx, tag);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      bus.req_valid = 1'b0;
      if (rq.size() == 0 && wq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain");
  endtask

  task automatic check_reset_outputs(input string tagn);
    chk({tagn, "_req_ready"}, bus.req_ready, 0);
    chk({tagn, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tagn, "_rsp_hit"},   bus.rsp_hit, 0);
    chk({tagn, "_ram_we"},    bus.ram_we, 0);
    chk({tagn, "_ram_din"},   bus.ram_din, 0);
    chk({tagn, "_ram_addr"},  bus.ram_addr, 0);
  endtask

  task automatic release_reset();
    int c0;
    bit ok = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    c0 = cyc;
`ifdef TAG_LOOKUP_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back('{a: AW'(i), d: '0});
      dir[i] = -1;
    end
    for (int k = 0; k < 3 * DEPTH; k++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) chk("init_ready_latency", cyc - c0, DEPTH);
    else    timeout("init_ready");
`else
    @(negedge clock);
    ok = bus.req_ready;
    chk("ready_after_reset", ok, 1);
    chk("ready_latency", cyc - c0, 1);
`endif
  endtask

  function automatic logic [TW-1:0] pick_tag();
    logic [TW-1:0] t;
    case ($urandom_range(0, 4))
      0: t = 13'h00A5;
      1: t = 13'h00A6;
      2: t = 13'h1FFF;
      3: t = 13'h0000;
      default: t = TW'($urandom_range(0, 3)) | 13'h1000;
    endcase
    return t;
  endfunction

  task automatic random_ops(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      send(r < 2, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), pick_tag(),
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  initial begin
    int saved;
    bus.req_valid = 1'b0;
    bus.req_inv   = 1'b0;
    bus.req_alloc = 1'b0;
    bus.req_index = '0;
    bus.req_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      preload[i] = DW'($urandom_range(0, (1 << DW) - 1));
      if (i == 3) preload[i] = '0;
      dir[i] = preload[i][DW-1] ? int'(preload[i][TW-1:0]) : -1;
    end
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    load_en = 1'b0;
    release_reset();

    // Directed: allocate on miss, hit, miss without alloc, invalidate, miss after invalidate.
    send(1'b0, 1'b1, 3, 13'h00A5, 0);
    send(1'b0, 1'b0, 3, 13'h00A5, 2);
    send(1'b0, 1'b0, 3, 13'h00A6, 0);
    send(1'b1, 1'b0, 3, 13'h0000, 1);
    send(1'b0, 1'b0, 3, 13'h00A5, 0);
    send(1'b0, 1'b1, DEPTH - 1, 13'h1FFF, 0);
    send(1'b0, 1'b0, DEPTH - 1, 13'h1FFF, 0);
    drain();

    random_ops(150);
    drain();

    // Reset dropped while an invalidate is in WRITE: no write commits, no response.
    saved = dir[5];
    send(1'b1, 1'b0, 5, 13'h0000, 1);
    @(negedge clock);
    chk("abort_pre_we", bus.ram_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_we_drop", bus.ram_we, 0);
    chk("abort_rsp", bus.rsp_valid, 0);
    bus.req_valid = 1'b0;
    rq.delete();
    dir[5] = saved;
    repeat (2) @(negedge clock);
    check_reset_outputs("abort");
    release_reset();

    send(1'b0, 1'b0, 5, 13'h00A5, 0);
    random_ops(40);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
